rf_writeback_queue: RTL and testbench

- Buffers register-file write requests produced by multi-cycle result sources (load unit, multiplier), using a valid/ready handshake.
- Drains exactly one request per cycle into the register file's single write port (WE3/A3/WD3 side).
- Provides two pending-write lookup ports so the decode stage can forward queued-but-unwritten data for read addresses A1/A2.
- Sits between execute/memory result producers and the register file.

---
 rtl/rf_writeback_queue.sv | 150 +++++++++++++++
 tb/tb_rf_writeback_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Purpose : circular write-back queue between multi-cycle result producers and the register-file write port.
// Latency : one cycle from acceptance to wr_en when empty; no combinational path from in_* to wr_*.
// Backpress: in_ready drops only when all DEPTH entries are occupied; the drain side never stalls.
//
// Ports:
//   clk, rst                   clock and asynchronous active-low reset
//   in_valid/in_ready/in_rd/in_data   producer request handshake
//   wr_en/wr_addr/wr_data      register-file write port (WE3/A3/WD3), driven by the head entry
//   flush                      synchronous discard of all queued entries
//   q1_addr/q1_hit/q1_data     pending-write lookup for decode A1
//   q2_addr/q2_hit/q2_data     pending-write lookup for decode A2
//   count                      number of occupied entries
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [DW-1:0]            in_data,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic                     flush,
  input  logic [AW-1:0]            q1_addr,
  output logic                     q1_hit,
  output logic [DW-1:0]            q1_data,
  input  logic [AW-1:0]            q2_addr,
  output logic                     q2_hit,
  output logic [DW-1:0]            q2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; contents are not reset, validity is tracked separately.
  logic [AW-1:0]    ent_rd   [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  logic accept;
  logic push;
  logic pop;

  // in_ready depends on state and rst only, never on in_valid.
  assign in_ready = rst & (occ < CW'(DEPTH));
  assign accept   = in_valid & in_ready;

  // Writes to x0 are handshaken but never stored; a flush drops the same-cycle push.
  assign push = accept & ~flush & (in_rd != '0);

  // The register file always takes the head, so presenting it is popping it.
  assign pop = rst & (occ != '0);

  assign wr_en   = pop;
  assign wr_addr = pop ? ent_rd[rd_ptr]   : '0;
  assign wr_data = pop ? ent_data[rd_ptr] : '0;
  assign count   = occ;

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      // The head write still lands this edge; everything else is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Per-entry valid flags. Push and pop never target the same slot in one
  // cycle: that would need the queue to be both empty and full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld <= '0;
    end else if (flush) begin
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
      end
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= in_rd;
      ent_data[wr_ptr] <= in_data;
    end
  end

  // Pending-write lookups. Entries are walked from the head (oldest) towards
  // the tail, so a later match overrides an earlier one and the newest wins.
  // The head is included: its register-file write only completes at the edge.
  logic [AW-1:0] look_addr [2];
  logic          look_hit  [2];
  logic [DW-1:0] look_data [2];

  assign look_addr[0] = q1_addr;
  assign look_addr[1] = q2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_lookup
    always_comb begin
      logic [PW-1:0] idx;
      look_hit[p]  = 1'b0;
      look_data[p] = '0;
      idx          = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (rst && ent_vld[idx] && (look_addr[p] != '0) && (ent_rd[idx] == look_addr[p])) begin
          look_hit[p]  = 1'b1;
          look_data[p] = ent_data[idx];
        end
      end
    end
  end

  assign q1_hit  = look_hit[0];
  assign q1_data = look_data[0];
  assign q2_hit  = look_hit[1];
  assign q2_data = look_data[1];

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Purpose : randomized + directed bench for rf_writeback_queue with a queue-based reference model.
// Latency : inputs driven 1 ns after posedge; monitor samples on negedge.
// Backpress: acceptance decided from the model occupancy, not from the DUT.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic [AW-1:0] q1_addr;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [AW-1:0] q2_addr;
  logic          q2_hit;
  logic [DW-1:0] q2_data;
  logic [$clog2(DEPTH):0] count;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flush    (flush),
    .q1_addr  (q1_addr),
    .q1_hit   (q1_hit),
    .q1_data  (q1_data),
    .q2_addr  (q2_addr),
    .q2_hit   (q2_hit),
    .q2_data  (q2_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the list of writes the register file has yet to receive.
  ent_t mq[$];
  logic pend_push;
  logic pend_fl;
  ent_t pend_ent;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Newest queued write to addr; x0 never matches.
  task automatic model_lookup(input logic [AW-1:0] addr, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != '0) begin
      foreach (mq[i]) begin
        if (mq[i].rd == addr) begin
          hit  = 1'b1;
          data = mq[i].data;
        end
      end
    end
  endtask

  // Monitor: compares every cycle against the model and retires the write
  // the register file takes at the coming edge.
  always @(negedge clk) begin
    logic          eh;
    logic [DW-1:0] ed;
    chk("count", 64'(count), 64'(mq.size()));
    chk("count_le_depth", 64'(count <= DEPTH), 64'd1);
    chk("in_ready", 64'(in_ready), 64'(rst && (mq.size() < DEPTH)));
    model_lookup(q1_addr, eh, ed);
    chk("q1_hit", 64'(q1_hit), 64'(eh));
    chk("q1_data", 64'(q1_data), 64'(ed));
    model_lookup(q2_addr, eh, ed);
    chk("q2_hit", 64'(q2_hit), 64'(eh));
    chk("q2_data", 64'(q2_data), 64'(ed));
    if (mq.size() > 0) begin
      chk("wr_en", 64'(wr_en), 64'd1);
      chk("wr_addr", 64'(wr_addr), 64'(mq[0].rd));
      chk("wr_data", 64'(wr_data), 64'(mq[0].data));
      void'(mq.pop_front());
    end else begin
      chk("wr_en_idle", 64'(wr_en), 64'd0);
      chk("wr_addr_idle", 64'(wr_addr), 64'd0);
      chk("wr_data_idle", 64'(wr_data), 64'd0);
    end
  end

  // One cycle of stimulus: apply what the previous edge did to the model,
  // then drive new inputs and decide what the next edge will do.
  task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                       input logic fl, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(posedge clk);
    if (pend_fl) mq.delete();
    else if (pend_push) mq.push_back(pend_ent);
    #1;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    flush    = fl;
    q1_addr  = a1;
    q2_addr  = a2;
    pend_fl   = rst && fl;
    pend_push = rst && v && !fl && (rd != '0) && (mq.size() < DEPTH);
    pend_ent  = '{rd: rd, data: d};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; flush = 1'b0;
    q1_addr = 5'd5; q2_addr = 5'd6;
    pend_push = 1'b0; pend_fl = 1'b0; pend_ent = '0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_q1_hit", 64'(q1_hit), 64'd0);
    chk("rst_q2_hit", 64'(q2_hit), 64'd0);

    // Single write, one-cycle latency.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
    #1;
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("single_fwd", 64'({q1_hit, q1_data}), {31'd0, 1'b1, 32'hDEADBEEF});
    drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
    #1;
    chk("single_done_wr_en", 64'(wr_en), 64'd0);
    chk("single_done_count", 64'(count), 64'd0);

    // x0 drop and forwarding.
    drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 5'd7);
    drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd0);
    #1;
    chk("x0_not_stored", 64'(count), 64'd0);
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd0);
    #1;
    chk("fwd_first", 64'({q1_hit, q1_data}), {31'd0, 1'b1, 32'h11});
    chk("fwd_x0_miss", 64'(q2_hit), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 5'd7, 5'd0);
    #1;
    chk("fwd_second", 64'({q1_hit, q1_data}), {31'd0, 1'b1, 32'h22});
    idle(2);

    // Continuous producer, rd=1..8.
    for (int i = 1; i <= 8; i++) drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, AW'(i), AW'(i - 1));
    idle(3);

    // Flush with a same-cycle push.
    drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd2, 5'd3);
    drive(1'b1, 5'd3, 32'h303, 1'b0, 5'd2, 5'd3);
    drive(1'b1, 5'd4, 32'h404, 1'b0, 5'd4, 5'd9);
    drive(1'b1, 5'd9, 32'h909, 1'b1, 5'd4, 5'd9);
    #1;
    chk("flush_head_wr_en", 64'(wr_en), 64'd1);
    chk("flush_head_wr_addr", 64'(wr_addr), 64'd4);
    drive(1'b0, '0, '0, 1'b0, 5'd9, 5'd4);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_wr_en", 64'(wr_en), 64'd0);
    chk("flush_no_rd9", 64'(q1_hit), 64'd0);
    idle(2);

    // Asynchronous reset while an entry is draining.
    drive(1'b1, 5'd6, 32'h606, 1'b0, 5'd6, 5'd0);
    drive(1'b0, '0, '0, 1'b0, 5'd6, 5'd0);
    #1;
    chk("pre_arst_wr_en", 64'(wr_en), 64'd1);
    #1 rst = 1'b0;
    mq.delete();
    pend_push = 1'b0;
    pend_fl   = 1'b0;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_q1_hit", 64'(q1_hit), 64'd0);
    drive(1'b1, 5'd8, 32'h808, 1'b0, 5'd8, 5'd0);
    drive(1'b0, '0, '0, 1'b0, 5'd8, 5'd0);
    rst = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_count", 64'(count), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 19) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
